prog_loader: RTL and testbench

Upstream program-load stage for the 12-bit microcontroller. It receives a program as a byte stream over a valid/ready handshake and packs each pair of bytes into one 12-bit instruction. It writes each instruction into program memory through the PMem load port (`load_en` / `load_addr` / `load_instr`). After the last instruction it raises `load_done`, which the MCU's LOAD state uses to advance to FETCH.

---
 rtl/prog_loader.sv | 214 +++++++++++++++++++++
 tb/tb_prog_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: program-load stage for the 12-bit MCU.
// Receives a byte stream over a valid/ready handshake. Each pair of bytes
// (low byte, then high byte) is packed into one 12-bit instruction, which is
// written to program memory through the PMem load port.
//
// Optional feature macro: PROG_LOADER_CKSUM_EN
//   When defined, one trailing checksum byte (the XOR of all program bytes)
//   is accepted after the final write. A match ends in DONE and a mismatch
//   ends in ERR. When undefined, the final write goes straight to DONE.
//
// All outputs come straight from flops. Their next values are decoded from
// the next state, so the outputs line up with the state register.
module prog_loader #(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              load_en,
  output logic [ADDR_W-1:0] load_addr,
  output logic [11:0]       load_instr,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_WRITE = 3'd3,
    S_CKSUM = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [11:0]       instr_q, instr_d;
  logic [7:0]        lo_q,    lo_d;
  logic              ready_q, ready_d;
  logic              en_q,    en_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
  logic              accept_s;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cksum_q, cksum_d;
`endif

  // A byte moves only when both sides agree in the same cycle.
  assign accept_s = byte_valid & ready_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    lo_d    = lo_q;
`ifdef PROG_LOADER_CKSUM_EN
    cksum_d = cksum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // Terminal and idle states all restart the same way on start.
        if (start) begin
          addr_d  = '0;
`ifdef PROG_LOADER_CKSUM_EN
          cksum_d = 8'h00;
`endif
          state_d = S_LO;
        end else begin
          state_d = state_q;
        end
      end

      S_LO: begin
        if (accept_s) begin
          lo_d    = byte_data;
`ifdef PROG_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ byte_data;
`endif
          state_d = S_HI;
        end else begin
          state_d = S_LO;
        end
      end

      S_HI: begin
        if (accept_s) begin
`ifdef PROG_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ byte_data;
`endif
          // A non-zero upper nibble means the stream is malformed. The
          // partial instruction is dropped and nothing is written.
          if (byte_data[7:4] != 4'h0) begin
            state_d = S_ERR;
          end else begin
            instr_d = {byte_data[3:0], lo_q};
            state_d = S_WRITE;
          end
        end else begin
          state_d = S_HI;
        end
      end

      S_WRITE: begin
        // The last address is not incremented, so it stays visible in DONE.
        if (addr_q == LAST_ADDR) begin
`ifdef PROG_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_LO;
        end
      end

`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (accept_s) begin
          if (byte_data == cksum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CKSUM;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The outputs are decoded from the next state so that each registered
    // output matches the state it describes.
    case (state_d)
      S_LO, S_HI: begin
        ready_d = 1'b1;
      end
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        ready_d = 1'b1;
      end
`endif
      default: begin
        ready_d = 1'b0;
      end
    endcase
    en_d   = (state_d == S_WRITE);
    busy_d = ready_d | en_d;
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  // State and datapath registers. Reset asserts asynchronously and drops any
  // partial instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      instr_q <= 12'h000;
      lo_q    <= 8'h00;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      lo_q    <= lo_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef PROG_LOADER_CKSUM_EN
  // Running XOR of every accepted program byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cksum_q <= 8'h00;
    end else begin
      cksum_q <= cksum_d;
    end
  end
`endif

  assign byte_ready = ready_q;
  assign load_en    = en_q;
  assign load_addr  = addr_q;
  assign load_instr = instr_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader. The reference model builds a byte stream,
// derives the expected PMem writes from the packing rules, and queues them.
// An independent monitor pops and compares an entry on every load_en.
module tb_prog_loader;

  localparam int DEPTH  = 10;
  localparam int ADDR_W = 8;
`ifdef PROG_LOADER_CKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [11:0]       load_instr;
  logic              load_done;
  logic              load_err;
  logic              busy;

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_instr (load_instr),
    .load_done  (load_done),
    .load_err   (load_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          prev_wr_cyc = 0;
  bit          gap_chk = 1'b0;
  logic [19:0] exp_q[$];
  logic [7:0]  stream[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst && load_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(load_addr), -1);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(load_addr), 32'(e[19:12]));
        check("write_instr", 32'(load_instr), 32'(e[11:0]));
      end
      if (gap_chk && load_addr != 8'd0) check("write_spacing", cyc - prev_wr_cyc, 3);
      prev_wr_cyc <= cyc;
    end
  end

  // Reference stream: DEPTH (lo, hi) pairs, an optional bad HI byte at
  // instruction err_at, and a trailing XOR byte when the checksum is built in.
  task automatic gen_stream(input int err_at, input logic [7:0] err_byte,
                            input bit bad_cks, input bit directed);
    logic [7:0] lo, hi, x;
    stream.delete();
    x = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      lo = 8'($urandom);
      hi = {4'h0, 4'($urandom)};
      if (directed && i == 0) begin
        lo = 8'h34;
        hi = 8'h02;
      end
      if (i == err_at) hi = err_byte;
      stream.push_back(lo);
      stream.push_back(hi);
      x = x ^ lo ^ hi;
    end
    if (CKS) stream.push_back(bad_cks ? (x ^ 8'h01) : x);
  endtask

  // Expected writes: instruction i is {hi[3:0], lo} at address i. The writes
  // stop at the first malformed HI byte or after n instructions.
  task automatic expect_writes(input int n);
    for (int i = 0; i < n; i++) begin
      if (stream[2*i+1][7:4] != 4'h0) break;
      exp_q.push_back({8'(i), stream[2*i+1][3:0], stream[2*i]});
    end
  endtask

  // Byte driver. vmode 0 holds valid high, 1 toggles it, 2 randomises it.
  task automatic drive(input int nbytes, input int vmode, input bit start_in_hi);
    int  idx;
    bit  v, tog;
    bit  finished;
    idx = 0;
    tog = 1'b1;
    finished = 1'b0;
    for (int g = 0; g < 3000; g++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      start = 1'b0;
      if (idx >= nbytes || load_err) begin
        finished = 1'b1;
        break;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      tog = ~tog;
      byte_valid = v;
      byte_data  = v ? stream[idx] : 8'($urandom);
      if (start_in_hi && idx == 7 && byte_ready) start = 1'b1;
      if (v && byte_ready) idx++;
    end
    if (!finished) check("driver_timeout", idx, nbytes);
  endtask

  task automatic run_load(input int err_at, input logic [7:0] err_byte, input bit bad_cks,
                          input int vmode, input bit start_in_hi, input bit directed);
    bit exp_done;
    int exp_addr;
    int w;
    gen_stream(err_at, err_byte, bad_cks, directed);
    expect_writes(DEPTH);
    exp_done = (err_at < 0) && !(CKS && bad_cks);
    exp_addr = (err_at < 0) ? DEPTH - 1 : err_at;
    gap_chk  = (vmode == 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_ready", 32'(byte_ready), 1);
    check("start_done_clr", 32'(load_done), 0);
    check("start_err_clr", 32'(load_err), 0);
    check("start_addr", 32'(load_addr), 0);
    drive(stream.size(), vmode, start_in_hi);
    w = 0;
    while (!(load_done || load_err) && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("final_done", 32'(load_done), 32'(exp_done));
    check("final_err", 32'(load_err), 32'(!exp_done));
    check("final_busy", 32'(busy), 0);
    check("final_ready", 32'(byte_ready), 0);
    check("final_addr", 32'(load_addr), exp_addr);
    check("missing_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int w;
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_en", 32'(load_en), 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_err", 32'(load_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(load_addr), 0);
    check("rst_instr", 32'(load_instr), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ignores_valid_busy", 32'(busy), 0);

    // Full load with valid held high. The first pair 0x34, 0x02 packs to 0x234.
    run_load(-1, 8'h00, 1'b0, 0, 1'b0, 1'b1);
    // Toggling valid gives the same writes with stretched spacing.
    run_load(-1, 8'h00, 1'b0, 1, 1'b0, 1'b0);
    // Malformed HI byte 0x12 at instruction 3.
    run_load(3, 8'h12, 1'b0, 0, 1'b0, 1'b0);
    // A later start clears the error and reloads.
    run_load(-1, 8'h00, 1'b0, 2, 1'b0, 1'b0);

    // Reset in the middle of a load, after five instructions.
    gen_stream(-1, 8'h00, 1'b0, 1'b0);
    expect_writes(5);
    gap_chk = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(10, 0, 1'b0);
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("pre_reset_writes", exp_q.size(), 0);
    @(negedge clk);
    check("pre_reset_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", 32'(byte_ready), 0);
    check("midrst_en", 32'(load_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_addr", 32'(load_addr), 0);
    check("midrst_instr", 32'(load_instr), 0);
    check("midrst_done", 32'(load_done), 0);
    check("midrst_err", 32'(load_err), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_load(-1, 8'h00, 1'b0, 0, 1'b0, 1'b0);

    // start during HI is ignored. The next load starts from DONE.
    run_load(-1, 8'h00, 1'b0, 0, 1'b1, 1'b0);
    run_load(-1, 8'h00, 1'b0, 2, 1'b0, 1'b0);

    // Checksum mismatch, then a good checksum. Without the checksum feature
    // both of these runs are plain loads that end in DONE.
    run_load(-1, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    run_load(-1, 8'h00, 1'b0, 1, 1'b0, 1'b0);

    // Randomised loads with an occasional malformed HI byte.
    for (int k = 0; k < 6; k++) begin
      int e;
      e = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1;
      run_load(e, {4'($urandom_range(1, 15)), 4'($urandom)}, 1'($urandom),
               int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
